// File: rtl/mini_calc3_core.sv
// Stack-machine arithmetic core: 8-bit opcodes executed against an internal LIFO,
// with precheck faults, optional saturating arithmetic and a flow-controlled dump port.
module mini_calc3_core #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned STACK_ADDR_SIZE = 3,
  parameter bit          SATURATE        = 1'b0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [7:0]                 Instruction,
  input  logic [DATA_WIDTH-1:0]      InputA,
  input  logic                       Execute,
  output logic                       Ready,
  output logic [DATA_WIDTH-1:0]      StackTop,
  output logic [STACK_ADDR_SIZE:0]   Depth,
  output logic                       StackEmpty,
  output logic                       StackFull,
  output logic                       OperationalError,
  output logic [2:0]                 ErrorCode,
  output logic [DATA_WIDTH-1:0]      DumpData,
  output logic                       DumpValid,
  output logic                       DumpLast,
  input  logic                       DumpNext
);

  localparam int unsigned Entries = 2 ** STACK_ADDR_SIZE;

  localparam logic [STACK_ADDR_SIZE:0]   DepthFull = {1'b1, {STACK_ADDR_SIZE{1'b0}}};
  localparam logic [STACK_ADDR_SIZE:0]   DepthOne  = {{STACK_ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [STACK_ADDR_SIZE:0]   DepthTwo  = {{(STACK_ADDR_SIZE - 1){1'b0}}, 2'b10};
  localparam logic [STACK_ADDR_SIZE-1:0] AddrZero  = {STACK_ADDR_SIZE{1'b0}};

  localparam logic [7:0] OpNop  = 8'h0F;
  localparam logic [7:0] OpPush = 8'h01;
  localparam logic [7:0] OpPop  = 8'h02;
  localparam logic [7:0] OpDup  = 8'h03;
  localparam logic [7:0] OpAdd  = 8'h04;
  localparam logic [7:0] OpSub  = 8'h05;
  localparam logic [7:0] OpMul  = 8'h06;
  localparam logic [7:0] OpDump = 8'h07;
  localparam logic [7:0] OpDiv  = 8'h08;
  localparam logic [7:0] OpSwap = 8'h09;
  localparam logic [7:0] OpMod  = 8'h0A;
  localparam logic [7:0] OpCls  = 8'h80;

  localparam logic [2:0] ErrNone      = 3'd0;
  localparam logic [2:0] ErrUnderflow = 3'd1;
  localparam logic [2:0] ErrOverflow  = 3'd2;
  localparam logic [2:0] ErrDivZero   = 3'd3;
  localparam logic [2:0] ErrIllegal   = 3'd4;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StDump} state_e;

  state_e                      state_q;
  logic [7:0]                  op_q;
  logic [DATA_WIDTH-1:0]       opa_q, opb_q;
  logic [STACK_ADDR_SIZE-1:0]  dump_idx_q;

  logic [DATA_WIDTH-1:0]       stack_mem [Entries];

  logic                        accept;
  logic [2:0]                  pre_err;
  logic [STACK_ADDR_SIZE-1:0]  addr_push, addr_top, addr_next, dump_nxt;
  logic [DATA_WIDTH-1:0]       top_rd, next_rd;

  logic [DATA_WIDTH:0]         sum;
  logic [2*DATA_WIDTH-1:0]     prod;
  logic                        div_zero;
  logic [DATA_WIDTH-1:0]       result;

  logic                        wr0_en, wr1_en;
  logic [STACK_ADDR_SIZE-1:0]  wr0_addr, wr1_addr;
  logic [DATA_WIDTH-1:0]       wr0_data, wr1_data;

  assign StackEmpty = (Depth == '0);
  assign StackFull  = (Depth == DepthFull);

  assign accept    = Execute && Ready && (state_q == StIdle);
  // A full stack wraps the low address bits to 0, but PUSH/DUP fault there anyway.
  assign addr_push = Depth[STACK_ADDR_SIZE-1:0];
  assign addr_top  = addr_push - 1'b1;
  assign addr_next = addr_push - 2'd2;
  assign top_rd    = stack_mem[addr_top];
  assign next_rd   = stack_mem[addr_next];
  assign dump_nxt  = dump_idx_q + 1'b1;

  always_comb begin
    pre_err = ErrNone;
    case (Instruction)
      OpNop, OpDump, OpCls: pre_err = ErrNone;
      OpPush: if (StackFull) pre_err = ErrOverflow;
      OpPop:  if (StackEmpty) pre_err = ErrUnderflow;
      OpDup: begin
        if (StackFull) pre_err = ErrOverflow;
        else if (StackEmpty) pre_err = ErrUnderflow;
      end
      OpAdd, OpSub, OpMul, OpDiv, OpSwap, OpMod: begin
        if (Depth < DepthTwo) pre_err = ErrUnderflow;
      end
      default: pre_err = ErrIllegal;
    endcase
  end

  always_comb begin
    sum      = {1'b0, opa_q} + {1'b0, opb_q};
    prod     = {{DATA_WIDTH{1'b0}}, opa_q} * {{DATA_WIDTH{1'b0}}, opb_q};
    div_zero = (opb_q == '0);
    result   = '0;
    case (op_q)
      OpAdd: result = (SATURATE && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
      OpSub: result = (SATURATE && (opa_q < opb_q)) ? '0 : opa_q - opb_q;
      OpMul: begin
        result = (SATURATE && (prod[2*DATA_WIDTH-1:DATA_WIDTH] != '0)) ? '1
                                                                       : prod[DATA_WIDTH-1:0];
      end
      OpDiv: result = div_zero ? '0 : opa_q / opb_q;
      OpMod: result = div_zero ? '0 : opa_q % opb_q;
      default: result = '0;
    endcase
  end

  // Two write ports so SWAP can exchange both entries on the EXEC edge.
  always_comb begin
    wr0_en   = 1'b0;
    wr0_addr = addr_push;
    wr0_data = InputA;
    wr1_en   = 1'b0;
    wr1_addr = addr_next;
    wr1_data = opa_q;
    if (accept && (pre_err == ErrNone)) begin
      if (Instruction == OpPush) begin
        wr0_en = 1'b1;
      end else if (Instruction == OpDup) begin
        wr0_en   = 1'b1;
        wr0_data = top_rd;
      end
    end
    if (state_q == StExec) begin
      case (op_q)
        OpSwap: begin
          wr0_en   = 1'b1;
          wr0_addr = addr_top;
          wr0_data = opb_q;
          wr1_en   = 1'b1;
        end
        OpAdd, OpSub, OpMul: begin
          wr0_en   = 1'b1;
          wr0_addr = addr_next;
          wr0_data = result;
        end
        OpDiv, OpMod: begin
          wr0_en   = !div_zero;
          wr0_addr = addr_next;
          wr0_data = result;
        end
        default: wr0_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (wr0_en) stack_mem[wr0_addr] <= wr0_data;
    if (wr1_en) stack_mem[wr1_addr] <= wr1_data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q          <= StIdle;
      op_q             <= OpNop;
      opa_q            <= '0;
      opb_q            <= '0;
      dump_idx_q       <= '0;
      Ready            <= 1'b1;
      StackTop         <= '0;
      Depth            <= '0;
      OperationalError <= 1'b0;
      ErrorCode        <= ErrNone;
      DumpData         <= '0;
      DumpValid        <= 1'b0;
      DumpLast         <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q             <= Instruction;
            OperationalError <= (pre_err != ErrNone);
            ErrorCode        <= pre_err;
            if (pre_err == ErrNone) begin
              case (Instruction)
                OpPush: begin
                  Depth    <= Depth + 1'b1;
                  StackTop <= InputA;
                end
                OpPop: begin
                  Depth    <= Depth - 1'b1;
                  StackTop <= (Depth >= DepthTwo) ? next_rd : '0;
                end
                OpDup: Depth <= Depth + 1'b1;
                OpCls: begin
                  Depth    <= '0;
                  StackTop <= '0;
                end
                OpDump: begin
                  if (!StackEmpty) begin
                    state_q    <= StDump;
                    Ready      <= 1'b0;
                    dump_idx_q <= AddrZero;
                    DumpValid  <= 1'b1;
                    DumpData   <= stack_mem[AddrZero];
                    DumpLast   <= (Depth == DepthOne);
                  end
                end
                OpAdd, OpSub, OpMul, OpDiv, OpSwap, OpMod: begin
                  state_q <= StFetch;
                  Ready   <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        StFetch: begin
          opa_q   <= top_rd;
          opb_q   <= next_rd;
          state_q <= StExec;
        end
        StExec: begin
          state_q <= StIdle;
          Ready   <= 1'b1;
          if (op_q == OpSwap) begin
            StackTop <= opb_q;
          end else if (((op_q == OpDiv) || (op_q == OpMod)) && div_zero) begin
            OperationalError <= 1'b1;
            ErrorCode        <= ErrDivZero;
          end else begin
            Depth    <= Depth - 1'b1;
            StackTop <= result;
          end
        end
        StDump: begin
          if (DumpNext) begin
            if (DumpLast) begin
              state_q   <= StIdle;
              Ready     <= 1'b1;
              DumpValid <= 1'b0;
              DumpLast  <= 1'b0;
              DumpData  <= '0;
            end else begin
              dump_idx_q <= dump_nxt;
              DumpData   <= stack_mem[dump_nxt];
              DumpLast   <= ({1'b0, dump_nxt} == (Depth - 1'b1));
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_calc3_core.sv
// Self-checking bench: a wrapping and a saturating core, each checked against a
// plain array-stack reference model under directed and randomized instruction streams.
module tb_mini_calc3_core;

  logic clk, rst;
  logic [1:0][7:0] instr, ina, top, ddata;
  logic [1:0]      exe, dnext, ready, empty, full, operr, dvalid, dlast;
  logic [1:0][3:0] depth;
  logic [1:0][2:0] ecode;

  int total = 0;
  int bad   = 0;

  // Reference model: one array stack per unit; unit 1 saturates.
  logic [7:0] ms [2][8];
  int         md [2];

  mini_calc3_core #(.DATA_WIDTH(8), .STACK_ADDR_SIZE(3), .SATURATE(1'b0)) u_wrap (
    .Clk(clk), .Reset(rst), .Instruction(instr[0]), .InputA(ina[0]), .Execute(exe[0]),
    .Ready(ready[0]), .StackTop(top[0]), .Depth(depth[0]), .StackEmpty(empty[0]),
    .StackFull(full[0]), .OperationalError(operr[0]), .ErrorCode(ecode[0]),
    .DumpData(ddata[0]), .DumpValid(dvalid[0]), .DumpLast(dlast[0]), .DumpNext(dnext[0])
  );

  mini_calc3_core #(.DATA_WIDTH(8), .STACK_ADDR_SIZE(3), .SATURATE(1'b1)) u_sat (
    .Clk(clk), .Reset(rst), .Instruction(instr[1]), .InputA(ina[1]), .Execute(exe[1]),
    .Ready(ready[1]), .StackTop(top[1]), .Depth(depth[1]), .StackEmpty(empty[1]),
    .StackFull(full[1]), .OperationalError(operr[1]), .ErrorCode(ecode[1]),
    .DumpData(ddata[1]), .DumpValid(dvalid[1]), .DumpLast(dlast[1]), .DumpNext(dnext[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_step(input int u, input logic [7:0] op, input logic [7:0] val,
                            output int e, output int busy);
    int d, a, b, r;
    d = md[u]; e = 0; busy = 0; a = 0; b = 0; r = 0;
    if (d > 0) a = int'(ms[u][d-1]);
    if (d > 1) b = int'(ms[u][d-2]);
    case (op)
      8'h0F, 8'h07: ;
      8'h01: if (d == 8) e = 2; else begin ms[u][d] = val; md[u] = d + 1; end
      8'h02: if (d == 0) e = 1; else md[u] = d - 1;
      8'h03: begin
        if (d == 8) e = 2;
        else if (d == 0) e = 1;
        else begin ms[u][d] = 8'(a); md[u] = d + 1; end
      end
      8'h04, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0A: begin
        if (d < 2) e = 1;
        else begin
          busy = 2;
          case (op)
            8'h04: begin r = a + b; r = (u == 1) ? ((r > 255) ? 255 : r) : r % 256; end
            8'h05: r = (u == 1) ? ((a < b) ? 0 : a - b) : (a - b + 256) % 256;
            8'h06: begin r = a * b; r = (u == 1) ? ((r > 255) ? 255 : r) : r % 256; end
            8'h08: if (b == 0) e = 3; else r = a / b;
            8'h0A: if (b == 0) e = 3; else r = a % b;
            default: ;
          endcase
          if (op == 8'h09) begin
            ms[u][d-1] = 8'(b);
            ms[u][d-2] = 8'(a);
          end else if (e == 0) begin
            ms[u][d-2] = 8'(r);
            md[u] = d - 1;
          end
        end
      end
      8'h80: md[u] = 0;
      default: e = 4;
    endcase
  endtask

  task automatic dump_run(input int u);
    int d;
    d = md[u];
    @(negedge clk); instr[u] = 8'h07; exe[u] = 1'b1;
    @(negedge clk); exe[u] = 1'b0;
    total++;
    if ({ready[u], dvalid[u]} !== 2'b01) begin
      bad++; $display("FAIL dump_start u%0d ready/valid=%b want 01", u, {ready[u], dvalid[u]});
    end
    for (int i = 0; i < d; i++) begin
      repeat (4) @(negedge clk);
      total++;
      if ({dvalid[u], dlast[u], ddata[u]} !== {1'b1, (i == d - 1), ms[u][i]}) begin
        bad++;
        $display("FAIL dump_entry u%0d i=%0d valid/last/data=%b/%b/%h want 1/%b/%h",
                 u, i, dvalid[u], dlast[u], ddata[u], (i == d - 1), ms[u][i]);
      end
      dnext[u] = 1'b1;
      @(negedge clk); dnext[u] = 1'b0;
    end
    total++;
    if ({ready[u], dvalid[u], dlast[u], ddata[u], depth[u]} !== {3'b100, 8'h00, 4'(d)}) begin
      bad++;
      $display("FAIL dump_end u%0d ready/valid/last/data/depth=%b/%b/%b/%h/%0d want 1/0/0/00/%0d",
               u, ready[u], dvalid[u], dlast[u], ddata[u], depth[u], d);
    end
  endtask

  task automatic run_op(input int u, input logic [7:0] op, input logic [7:0] val);
    int e, busy, cnt;
    logic [7:0] et;
    if (op == 8'h07 && md[u] > 0) begin
      dump_run(u);
      return;
    end
    model_step(u, op, val, e, busy);
    @(negedge clk); instr[u] = op; ina[u] = val; exe[u] = 1'b1;
    @(negedge clk); exe[u] = 1'b0;
    cnt = 0;
    while (!ready[u] && cnt < 10) begin cnt++; @(negedge clk); end
    et = (md[u] > 0) ? ms[u][md[u]-1] : 8'h00;
    total++;
    if (cnt !== busy) begin
      bad++; $display("FAIL busy u%0d op=%h cycles=%0d want %0d", u, op, cnt, busy);
    end
    total++;
    if ({depth[u], top[u]} !== {4'(md[u]), et}) begin
      bad++; $display("FAIL stack u%0d op=%h depth/top=%0d/%h want %0d/%h",
                      u, op, depth[u], top[u], md[u], et);
    end
    total++;
    if ({operr[u], ecode[u]} !== {(e != 0), 3'(e)}) begin
      bad++; $display("FAIL error u%0d op=%h err/code=%b/%0d want %b/%0d",
                      u, op, operr[u], ecode[u], (e != 0), e);
    end
    total++;
    if ({empty[u], full[u]} !== {(md[u] == 0), (md[u] == 8)}) begin
      bad++; $display("FAIL flags u%0d op=%h empty/full=%b/%b", u, op, empty[u], full[u]);
    end
  endtask

  task automatic test_reset;
    logic [28:0] got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      got = {ready[u], depth[u], top[u], operr[u], ecode[u], dvalid[u], dlast[u], ddata[u],
             empty[u], full[u]};
      total++;
      if (got !== {1'b1, 4'd0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0}) begin
        bad++; $display("FAIL reset u%0d outputs=%h want %h", u, got, 29'h10000002);
      end
    end
    rst = 1'b0;
    md[0] = 0; md[1] = 0;
  endtask

  task automatic test_sub;
    for (int u = 0; u < 2; u++) begin
      run_op(u, 8'h80, 8'h00);
      run_op(u, 8'h01, 8'd5);
      run_op(u, 8'h01, 8'd3);
      run_op(u, 8'h05, 8'h00);
      total++;
      if (top[u] !== ((u == 0) ? 8'hFE : 8'h00)) begin
        bad++; $display("FAIL sub_result u%0d top=%h", u, top[u]);
      end
    end
  endtask

  task automatic test_overflow;
    run_op(0, 8'h80, 8'h00);
    for (int i = 0; i < 8; i++) run_op(0, 8'h01, 8'(i * 3 + 1));
    run_op(0, 8'h01, 8'h11);
    run_op(0, 8'h03, 8'h00);
    run_op(0, 8'h0F, 8'h00);
  endtask

  task automatic test_underflow_divzero;
    run_op(0, 8'h80, 8'h00);
    run_op(0, 8'h02, 8'h00);
    run_op(0, 8'h01, 8'd7);
    run_op(0, 8'h04, 8'h00);
    run_op(0, 8'h01, 8'd0);
    run_op(0, 8'h01, 8'd9);
    run_op(0, 8'h08, 8'h00);
    run_op(0, 8'h0A, 8'h00);
    run_op(0, 8'h33, 8'h00);
    run_op(0, 8'hFF, 8'h00);
  endtask

  task automatic test_mul_swap;
    for (int u = 0; u < 2; u++) begin
      run_op(u, 8'h80, 8'h00);
      run_op(u, 8'h01, 8'd200);
      run_op(u, 8'h01, 8'd2);
      run_op(u, 8'h06, 8'h00);
      run_op(u, 8'h01, 8'd1);
      run_op(u, 8'h01, 8'd2);
      run_op(u, 8'h09, 8'h00);
      run_op(u, 8'h02, 8'h00);
    end
  endtask

  task automatic test_dump;
    run_op(0, 8'h80, 8'h00);
    run_op(0, 8'h07, 8'h00);
    run_op(0, 8'h01, 8'd1);
    run_op(0, 8'h01, 8'd2);
    run_op(0, 8'h01, 8'd3);
    run_op(0, 8'h07, 8'h00);
  endtask

  task automatic test_back_to_back;
    int e, busy, cnt;
    run_op(0, 8'h80, 8'h00);
    run_op(0, 8'h01, 8'd4);
    run_op(0, 8'h01, 8'd6);
    model_step(0, 8'h04, 8'h00, e, busy);
    @(negedge clk); instr[0] = 8'h04; exe[0] = 1'b1;
    @(negedge clk); instr[0] = 8'h01; ina[0] = 8'h55;
    cnt = 0;
    while (!ready[0] && cnt < 10) begin cnt++; @(negedge clk); end
    exe[0] = 1'b0;
    total++;
    if ({cnt[3:0], depth[0], top[0]} !== {4'(busy), 4'(md[0]), ms[0][md[0]-1]}) begin
      bad++; $display("FAIL ignored_exec cycles/depth/top=%0d/%0d/%h want %0d/%0d/%h",
                      cnt, depth[0], top[0], busy, md[0], ms[0][md[0]-1]);
    end
  endtask

  task automatic test_reset_mid;
    logic [28:0] got;
    for (int k = 0; k < 2; k++) begin
      run_op(0, 8'h01, 8'd1);
      run_op(0, 8'h01, 8'd2);
      @(negedge clk); instr[0] = (k == 0) ? 8'h04 : 8'h07; exe[0] = 1'b1;
      @(posedge clk); #1 exe[0] = 1'b0;
      rst = 1'b1;
      #1;
      got = {ready[0], depth[0], top[0], operr[0], ecode[0], dvalid[0], dlast[0], ddata[0],
             empty[0], full[0]};
      total++;
      if (got !== {1'b1, 4'd0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0}) begin
        bad++; $display("FAIL reset_mid k=%0d outputs=%h want %h", k, got, 29'h10000002);
      end
      @(negedge clk); rst = 1'b0;
      md[0] = 0; md[1] = 0;
    end
  endtask

  task automatic test_random;
    logic [7:0] op, val;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 15))
        0, 1, 2, 3: op = 8'h01;
        4: op = 8'h02;   5: op = 8'h03;   6: op = 8'h04;   7: op = 8'h05;
        8: op = 8'h06;   9: op = 8'h08;  10: op = 8'h0A;  11: op = 8'h09;
        12: op = 8'h07; 13: op = 8'h0F;  14: op = 8'(($urandom_range(0, 1) == 0) ? 8'h55 : 8'h0B);
        default: op = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'h01;
      endcase
      val = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run_op(n % 2, op, val);
    end
  endtask

  initial begin
    rst = 1'b0; exe = '0; dnext = '0; instr = '0; ina = '0;
    md[0] = 0; md[1] = 0;
    test_reset;
    test_sub;
    test_overflow;
    test_underflow_divzero;
    test_mul_swap;
    test_dump;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
